// File: rtl/calc_key_entry.sv
// Calculator key-entry front end: turns debounced key levels into single key
// events and assembles two decimal operands plus an operator for the ALU.
module calc_key_entry #(
    parameter int W          = 16,
    parameter int MAX_DIGITS = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [15:0]  btn_db,
    input  logic [W-1:0] result_in,
    output logic [W-1:0] operand_a,
    output logic [W-1:0] operand_b,
    output logic [1:0]   op_code,
    output logic         exec,
    output logic [W-1:0] disp_val,
    output logic         key_valid,
    output logic [3:0]   key_code
);

    localparam int CW = $clog2(MAX_DIGITS + 1);

    // The largest MAX_DIGITS-digit decimal number must fit in W bits.
    generate
        if ((64'(10) ** MAX_DIGITS) - 64'(1) >= (64'(1) << W)) begin : g_bad_params
            $error("calc_key_entry: 10**MAX_DIGITS-1 does not fit in W bits");
        end
    endgenerate

    typedef enum logic [1:0] {
        ENTER_A  = 2'd0,
        ENTER_OP = 2'd1,
        ENTER_B  = 2'd2,
        DONE     = 2'd3
    } state_t;

    state_t        state_q;
    logic [15:0]   prev_q;
    logic [W-1:0]  operand_a_q, operand_b_q;
    logic [CW-1:0] a_cnt_q, b_cnt_q;
    logic [1:0]    op_code_q;
    logic          exec_q, key_valid_q;
    logic [3:0]    key_code_q;

    logic [15:0]   new_keys;
    logic          ev;
    logic [3:0]    ev_code;
    logic          is_digit, is_op, is_eq, is_clr;
    logic [W-1:0]  digit_w, acc_a, acc_b;
    logic [1:0]    op_sel;

    // 'C' outranks everything; otherwise the lowest newly pressed index wins.
    always_comb begin
        new_keys = btn_db & ~prev_q;
        ev       = |new_keys;
        ev_code  = 4'd0;
        if (new_keys[15]) begin
            ev_code = 4'd15;
        end else begin
            for (int i = 14; i >= 0; i--) begin
                if (new_keys[i]) ev_code = 4'(i);
            end
        end
        is_digit = (ev_code <= 4'd9);
        is_op    = (ev_code >= 4'd10) && (ev_code <= 4'd13);
        is_eq    = (ev_code == 4'd14);
        is_clr   = (ev_code == 4'd15);
        op_sel   = 2'(ev_code - 4'd10);
        digit_w  = W'(ev_code);
        acc_a    = operand_a_q * W'(10) + digit_w;
        acc_b    = operand_b_q * W'(10) + digit_w;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ENTER_A;
            prev_q      <= 16'hFFFF;
            operand_a_q <= '0;
            operand_b_q <= '0;
            a_cnt_q     <= '0;
            b_cnt_q     <= '0;
            op_code_q   <= 2'b00;
            exec_q      <= 1'b0;
            key_valid_q <= 1'b0;
            key_code_q  <= 4'd0;
        end else begin
            prev_q      <= btn_db;
            exec_q      <= 1'b0;
            key_valid_q <= 1'b0;
            if (ev) begin
                key_valid_q <= 1'b1;
                key_code_q  <= ev_code;
                if (is_clr) begin
                    state_q     <= ENTER_A;
                    operand_a_q <= '0;
                    operand_b_q <= '0;
                    a_cnt_q     <= '0;
                    b_cnt_q     <= '0;
                    op_code_q   <= 2'b00;
                end else begin
                    case (state_q)
                        ENTER_A: begin
                            if (is_digit && (a_cnt_q < CW'(MAX_DIGITS))) begin
                                operand_a_q <= acc_a;
                                a_cnt_q     <= a_cnt_q + CW'(1);
                            end else if (is_op && (a_cnt_q != '0)) begin
                                op_code_q <= op_sel;
                                state_q   <= ENTER_OP;
                            end
                        end
                        ENTER_OP: begin
                            if (is_op) begin
                                op_code_q <= op_sel;
                            end else if (is_digit) begin
                                operand_b_q <= digit_w;
                                b_cnt_q     <= CW'(1);
                                state_q     <= ENTER_B;
                            end
                        end
                        ENTER_B: begin
                            if (is_digit && (b_cnt_q < CW'(MAX_DIGITS))) begin
                                operand_b_q <= acc_b;
                                b_cnt_q     <= b_cnt_q + CW'(1);
                            end else if (is_eq) begin
                                exec_q  <= 1'b1;
                                state_q <= DONE;
                            end
                        end
                        DONE: begin
                            // Chaining: an operator carries the result forward as A,
                            // with A marked full so stray digits cannot extend it.
                            if (is_digit) begin
                                operand_a_q <= digit_w;
                                a_cnt_q     <= CW'(1);
                                operand_b_q <= '0;
                                b_cnt_q     <= '0;
                                state_q     <= ENTER_A;
                            end else if (is_op) begin
                                operand_a_q <= result_in;
                                a_cnt_q     <= CW'(MAX_DIGITS);
                                operand_b_q <= '0;
                                b_cnt_q     <= '0;
                                op_code_q   <= op_sel;
                                state_q     <= ENTER_OP;
                            end
                        end
                        default: state_q <= ENTER_A;
                    endcase
                end
            end
        end
    end

    always_comb begin
        case (state_q)
            ENTER_B: disp_val = operand_b_q;
            DONE:    disp_val = result_in;
            default: disp_val = operand_a_q;
        endcase
    end

    assign operand_a = operand_a_q;
    assign operand_b = operand_b_q;
    assign op_code   = op_code_q;
    assign exec      = exec_q;
    assign key_valid = key_valid_q;
    assign key_code  = key_code_q;

endmodule

// File: tb/tb_calc_key_entry.sv
// Directed-vector bench for calc_key_entry: key sequences with hand-computed
// operands, op codes and strobes.
module tb_calc_key_entry;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic [15:0]  btn_db;
    logic [W-1:0] result_in;
    logic [W-1:0] operand_a, operand_b, disp_val;
    logic [1:0]   op_code;
    logic         exec, key_valid;
    logic [3:0]   key_code;

    int errors = 0;
    int checks = 0;

    calc_key_entry #(.W(W), .MAX_DIGITS(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_db    (btn_db),
        .result_in (result_in),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .op_code   (op_code),
        .exec      (exec),
        .disp_val  (disp_val),
        .key_valid (key_valid),
        .key_code  (key_code)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s = %0d", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Press key k (level held for one cycle); outputs are sampled after the edge.
    task automatic press(input int k);
        btn_db = 16'h0001 << k;
        tick();
    endtask

    task automatic rel();
        btn_db = 16'h0000;
        tick();
        chk("kv_after_release", 32'(key_valid), 32'd0);
        chk("exec_after_release", 32'(exec), 32'd0);
    endtask

    initial begin
        rst       = 1'b1;
        btn_db    = 16'h0008;
        result_in = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_a", 32'(operand_a), 32'd0);
        chk("rst_b", 32'(operand_b), 32'd0);
        chk("rst_op", 32'(op_code), 32'd0);
        chk("rst_exec", 32'(exec), 32'd0);
        chk("rst_kv", 32'(key_valid), 32'd0);
        chk("rst_code", 32'(key_code), 32'd0);
        chk("rst_disp", 32'(disp_val), 32'd0);

        // Key 3 held through reset, then released, then pressed.
        rst = 1'b0;
        tick();
        chk("held_no_event", 32'(key_valid), 32'd0);
        btn_db = 16'h0000;
        tick();
        chk("release_no_event", 32'(key_valid), 32'd0);
        press(3);
        chk("p3_kv", 32'(key_valid), 32'd1);
        chk("p3_code", 32'(key_code), 32'd3);
        chk("p3_a", 32'(operand_a), 32'd3);
        chk("p3_disp", 32'(disp_val), 32'd3);
        rel();
        chk("code_holds", 32'(key_code), 32'd3);

        // Five digits then '+': fifth digit dropped but still reported.
        press(15); rel();
        chk("clr_a", 32'(operand_a), 32'd0);
        for (int d = 1; d <= 5; d++) begin
            press(d);
            chk("digit_kv", 32'(key_valid), 32'd1);
            rel();
        end
        chk("a_1234", 32'(operand_a), 32'd1234);
        chk("code_5", 32'(key_code), 32'd5);
        press(10);
        chk("plus_op", 32'(op_code), 32'd0);
        chk("plus_code", 32'(key_code), 32'd10);
        rel();
        press(14);
        chk("eq_in_op_exec", 32'(exec), 32'd0);
        chk("eq_in_op_kv", 32'(key_valid), 32'd1);
        rel();

        // 7 * - 6 (+ ignored) = ; held '=' gives one exec.
        press(15); rel();
        press(7);  rel();
        press(12);
        chk("mul_op", 32'(op_code), 32'd2);
        rel();
        press(11);
        chk("sub_op", 32'(op_code), 32'd1);
        rel();
        press(6);
        chk("b_6", 32'(operand_b), 32'd6);
        chk("disp_b", 32'(disp_val), 32'd6);
        rel();
        press(10);
        chk("op_in_b_ignored", 32'(op_code), 32'd1);
        chk("op_in_b_b", 32'(operand_b), 32'd6);
        chk("op_in_b_exec", 32'(exec), 32'd0);
        rel();
        press(14);
        chk("eq_exec", 32'(exec), 32'd1);
        chk("eq_a", 32'(operand_a), 32'd7);
        tick();
        chk("eq_held_exec", 32'(exec), 32'd0);
        chk("eq_held_kv", 32'(key_valid), 32'd0);
        rel();

        // Chaining from DONE with result 42.
        result_in = 16'd42;
        #1;
        chk("done_disp", 32'(disp_val), 32'd42);
        press(14);
        chk("eq_in_done_exec", 32'(exec), 32'd0);
        rel();
        press(13);
        chk("chain_a", 32'(operand_a), 32'd42);
        chk("chain_op", 32'(op_code), 32'd3);
        chk("chain_b", 32'(operand_b), 32'd0);
        rel();
        press(2);
        chk("chain_b2", 32'(operand_b), 32'd2);
        rel();
        press(14);
        chk("chain_exec", 32'(exec), 32'd1);
        rel();
        result_in = 16'd21;
        press(5);
        chk("new_a", 32'(operand_a), 32'd5);
        chk("new_b", 32'(operand_b), 32'd0);
        chk("new_disp", 32'(disp_val), 32'd5);
        rel();
        press(1);
        chk("new_a_51", 32'(operand_a), 32'd51);
        rel();

        // Simultaneous 4 and 'C' during B entry; then 2 and 9 together.
        press(15); rel();
        press(1);  rel();
        press(10); rel();
        press(8);  rel();
        chk("b_8", 32'(operand_b), 32'd8);
        btn_db = 16'h8010;
        tick();
        chk("clr_wins_code", 32'(key_code), 32'd15);
        chk("clr_wins_a", 32'(operand_a), 32'd0);
        chk("clr_wins_b", 32'(operand_b), 32'd0);
        chk("clr_wins_exec", 32'(exec), 32'd0);
        rel();
        btn_db = 16'h0204;
        tick();
        chk("low_wins_code", 32'(key_code), 32'd2);
        chk("low_wins_a", 32'(operand_a), 32'd2);
        rel();

        // Operator and '=' with no digits yet are ignored.
        press(15); rel();
        press(11);
        chk("early_op_kv", 32'(key_valid), 32'd1);
        chk("early_op_op", 32'(op_code), 32'd0);
        chk("early_op_a", 32'(operand_a), 32'd0);
        rel();
        press(14);
        chk("early_eq_exec", 32'(exec), 32'd0);
        rel();
        press(9);
        chk("early_then_a", 32'(operand_a), 32'd9);
        rel();

        // Asynchronous reset mid-entry.
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_a", 32'(operand_a), 32'd0);
        #1;
        rst = 1'b0;
        tick();
        chk("post_rst_kv", 32'(key_valid), 32'd0);
        press(4);
        chk("post_rst_a", 32'(operand_a), 32'd4);
        rel();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/calc_key_entry.md
Name: calc_key_entry

Overview:
- Sits directly downstream of the per-button debouncers in the calculator datapath.
- Turns 16 debounced key levels into single key events (rising-edge detect plus priority encode).
- Runs an entry state machine that builds two decimal operands and an operator, then fires a one-cycle execute strobe to the ALU.
- Supports chaining: an operator pressed after a result loads that result as the next operand A.

Parameters:
W, 16, operand width in bits (binary, unsigned).
MAX_DIGITS, 4, maximum decimal digits per operand; 10^MAX_DIGITS-1 must be < 2^W (elaboration-time check).

Ports:
clk  input  1  system clock; all state updates on rising edge.
rst  input  1  asynchronous, active-high reset.
btn_db  input  16  debounced key levels; bits 0-9 = digits 0-9, 10 '+', 11 '-', 12 '*', 13 '/', 14 '=', 15 'C'.
result_in  input  W  ALU result, used only for chaining from DONE.
operand_a  output  W  latched operand A.
operand_b  output  W  latched operand B.
op_code  output  2  00 add, 01 sub, 10 mul, 11 div.
exec  output  1  one-cycle strobe: operands and op valid for the ALU.
disp_val  output  W  value being entered (A in ENTER_A/OP, B in ENTER_B, result_in in DONE).
key_valid  output  1  one-cycle pulse per accepted key event.
key_code  output  4  index of the last event; holds between events.

Behaviour:
- Reset (async, active-high): all outputs 0; state ENTER_A; digit counters 0; prev_q = 16'hFFFF, so keys held through reset produce no event until released and pressed again.
- Edge detect:
  - new = btn_db & ~prev_q; prev_q <= btn_db every cycle.
  - Event when new != 0. Priority: bit 15 ('C') wins; otherwise the lowest set index wins. Other simultaneous new bits are dropped.
- Latency:
  - Every effect of an event (state, operands, key_valid, key_code, exec) is visible after the same rising edge at which the edge is first seen. exec and key_valid are high for exactly that one cycle.
  - A held key produces one event only. Release and re-press produces a new event.
- Accumulate rule: val <= val*10 + d, computed in W bits.
  - Only when cnt < MAX_DIGITS; cnt increments.
  - Extra digits are ignored but still pulse key_valid.
- State machine:
  - ENTER_A:
    - digit: accumulate into operand_a.
    - operator: if a_cnt > 0, latch op_code and go to ENTER_OP; if a_cnt = 0, ignored.
    - '=': ignored.
  - ENTER_OP:
    - operator: replaces op_code.
    - digit: operand_b <= d, b_cnt = 1, go to ENTER_B.
    - '=': ignored.
  - ENTER_B:
    - digit: accumulate into operand_b.
    - '=': exec=1 and go to DONE.
    - operator: ignored (no implicit evaluate).
  - DONE:
    - digit: operand_a <= d, a_cnt = 1, operand_b <= 0, b_cnt = 0, go to ENTER_A.
    - operator: operand_a <= result_in (sampled that cycle), a_cnt = MAX_DIGITS (further digits blocked), operand_b <= 0, latch op_code, go to ENTER_OP.
    - '=': ignored.
  - 'C' in any state: operands, counters and op_code = 0; go to ENTER_A; key_valid=1, key_code=15. exec is never asserted on 'C'.
- Ignored keys (per state) still pulse key_valid and update key_code. No other outputs change.
- exec can be high only on the ENTER_B to DONE transition. Back-to-back exec requires a new B entry.
- Reset asserted mid-entry clears immediately, without waiting for clk. The first edge after deassertion obeys the prev_q rule.

Test Plan:
- Reset with btn_db[3] held, then release, then press 3 → no event while held or on release. After the press: key_valid 1 cycle, key_code=3, operand_a=3.
- Press 1,2,3,4,5 then '+' → operand_a=1234 (fifth digit ignored, key_valid still pulsed), op_code=00, state ENTER_OP.
- Sequence 7, '*', '-', 6, '=' → op_code=01, operand_b=6, exec high exactly one cycle after '=' edge. A held '=' gives no second exec.
- From DONE with result_in=42, press '/' then 2 then '=' → operand_a=42, op_code=11, operand_b=2, exec pulse. Then press 5 → operand_a=5, operand_b=0, state ENTER_A.
- btn_db bits 4 and 15 rise in the same cycle mid-entry of B → clear wins: all operands 0, key_code=15, ENTER_A, no exec. Bits 2 and 9 together → digit 2 only.
- '+' or '=' pressed first after reset → ignored (operand_a=0, state ENTER_A), key_valid still pulses.
